// File: rtl/mem_bist_controller.sv
// ============================================================================
// mem_bist_controller: two-pass write/read-compare march BIST for a
// single-port synchronous RAM with registered read output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bist_controller #(
   parameter int ADD_WIDTH  = 6,
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 64,
   parameter int ERR_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  mem_read,
   output logic                  mem_wr,
   output logic [ADD_WIDTH-1:0]  mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_write,
   input  logic [DATA_WIDTH-1:0] mem_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_WIDTH-1:0]  err_count,
   output logic [ADD_WIDTH-1:0]  fail_addr
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_W0   = 3'd1;
   localparam logic [2:0] S_R0   = 3'd2;
   localparam logic [2:0] S_D0   = 3'd3;
   localparam logic [2:0] S_W1   = 3'd4;
   localparam logic [2:0] S_R1   = 3'd5;
   localparam logic [2:0] S_D1   = 3'd6;
   localparam logic [2:0] S_DONE = 3'd7;

   localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(DEPTH - 1);
   localparam logic [ERR_WIDTH-1:0] ERR_MAX   = '1;

   logic [2:0]                state_q, state_d;
   logic [ADD_WIDTH-1:0]      addr_q, addr_d;
   logic                      cmp_valid_q, cmp_valid_d;
   logic [DATA_WIDTH-1:0]     exp_data_q, exp_data_d;
   logic [ADD_WIDTH-1:0]      exp_addr_q, exp_addr_d;
   logic [ERR_WIDTH-1:0]      err_count_q, err_count_d;
   logic [ADD_WIDTH-1:0]      fail_addr_q, fail_addr_d;
   logic                      first_fail_q, first_fail_d;
   logic                      pass_q, pass_d;

   logic [ADD_WIDTH+DATA_WIDTH-1:0] addr_ext;
   logic [DATA_WIDTH-1:0]           pattern;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      cmp_valid_d    = 1'b0;
      exp_data_d     = exp_data_q;
      exp_addr_d     = exp_addr_q;
      err_count_d    = err_count_q;
      fail_addr_d    = fail_addr_q;
      first_fail_d   = first_fail_q;
      pass_d         = pass_q;
      mem_read       = 1'b0;
      mem_wr         = 1'b0;
      mem_address    = '0;
      mem_data_write = '0;

      // Zero-extend before slicing so the pattern works for any width ratio.
      addr_ext = {{DATA_WIDTH{1'b0}}, addr_q};
      pattern  = addr_ext[DATA_WIDTH-1:0];
      if (state_q == S_W1 || state_q == S_R1) begin
         pattern = ~pattern;
      end

      if (cmp_valid_q && (mem_out != exp_data_q)) begin
         if (err_count_q != ERR_MAX) begin
            err_count_d = err_count_q + 1'b1;
         end
         if (!first_fail_q) begin
            fail_addr_d = exp_addr_q;
         end
         first_fail_d = 1'b1;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_W0;
               addr_d       = '0;
               err_count_d  = '0;
               fail_addr_d  = '0;
               first_fail_d = 1'b0;
               pass_d       = 1'b0;
            end
         end
         S_W0, S_W1: begin
            mem_wr         = 1'b1;
            mem_address    = addr_q;
            mem_data_write = pattern;
            addr_d         = addr_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
               addr_d  = '0;
               state_d = (state_q == S_W0) ? S_R0 : S_R1;
            end
         end
         S_R0, S_R1: begin
            mem_read    = 1'b1;
            mem_address = addr_q;
            cmp_valid_d = 1'b1;
            exp_data_d  = pattern;
            exp_addr_d  = addr_q;
            addr_d      = addr_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
               addr_d  = '0;
               state_d = (state_q == S_R0) ? S_D0 : S_D1;
            end
         end
         S_D0: state_d = S_W1;
         S_D1: begin
            state_d = S_DONE;
            // Include the final compare landing in this drain cycle.
            pass_d  = (err_count_d == '0);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         cmp_valid_q  <= 1'b0;
         exp_data_q   <= '0;
         exp_addr_q   <= '0;
         err_count_q  <= '0;
         fail_addr_q  <= '0;
         first_fail_q <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cmp_valid_q  <= cmp_valid_d;
         exp_data_q   <= exp_data_d;
         exp_addr_q   <= exp_addr_d;
         err_count_q  <= err_count_d;
         fail_addr_q  <= fail_addr_d;
         first_fail_q <= first_fail_d;
         pass_q       <= pass_d;
      end
   end

   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign pass      = pass_q;
   assign err_count = err_count_q;
   assign fail_addr = fail_addr_q;

endmodule

`default_nettype wire
